// File: rtl/ram_rmw_pkg.sv
// Shared definitions for the ToeCam bit-vector RAM read-modify-write controller.
// The RMW_NEW_VAL macro is the single definition of the update rule (set wins over clear).
`ifndef RAM_RMW_PKG_DEFS
`define RAM_RMW_PKG_DEFS
`define RMW_NEW_VAL(o, s, c) (((o) & ~(c)) | (s))
`endif

package ram_rmw_pkg;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/ram_rmw_ctrl_if.sv
// Request/RAM bus bundle for ram_rmw_ctrl; master is the controller side.
// Response signals exist only when RAM_RMW_RSP_EN is defined.
interface ram_rmw_ctrl_if #(
    parameter int A = 9,
    parameter int D = 64
);
    logic         InitDone;
    logic         ReqValid;
    logic         ReqReady;
    logic [A-1:0] ReqAddr;
    logic [D-1:0] ReqSetMask;
    logic [D-1:0] ReqClrMask;
    logic         RamRdEnb;
    logic [A-1:0] RamRdAddr;
    logic [D-1:0] RamRdData;
    logic         RamWrEnb;
    logic [A-1:0] RamWrAddr;
    logic [D-1:0] RamWrData;
`ifdef RAM_RMW_RSP_EN
    logic         RspValid;
    logic [A-1:0] RspAddr;
    logic [D-1:0] RspOldData;
    logic [D-1:0] RspNewData;

    modport master (
        output InitDone, ReqReady, RamRdEnb, RamRdAddr, RamWrEnb, RamWrAddr, RamWrData,
        output RspValid, RspAddr, RspOldData, RspNewData,
        input  ReqValid, ReqAddr, ReqSetMask, ReqClrMask, RamRdData
    );
    modport slave (
        input  InitDone, ReqReady, RamRdEnb, RamRdAddr, RamWrEnb, RamWrAddr, RamWrData,
        input  RspValid, RspAddr, RspOldData, RspNewData,
        output ReqValid, ReqAddr, ReqSetMask, ReqClrMask, RamRdData
    );
`else
    modport master (
        output InitDone, ReqReady, RamRdEnb, RamRdAddr, RamWrEnb, RamWrAddr, RamWrData,
        input  ReqValid, ReqAddr, ReqSetMask, ReqClrMask, RamRdData
    );
    modport slave (
        input  InitDone, ReqReady, RamRdEnb, RamRdAddr, RamWrEnb, RamWrAddr, RamWrData,
        output ReqValid, ReqAddr, ReqSetMask, ReqClrMask, RamRdData
    );
`endif
endinterface

// File: rtl/ram_rmw_ctrl.sv
// Read-modify-write initiator: zero-sweeps the RAM after reset, then applies one set/clear
// update per cycle with distance-1 forwarding. RAM_RMW_RSP_EN adds a registered response.
module ram_rmw_ctrl
    import ram_rmw_pkg::*;
#(
    parameter int A = 9,
    parameter int D = 64
) (
    input  logic            Clk,
    input  logic            Rst_n,
    ram_rmw_ctrl_if.master  Bus
);

    localparam logic [A:0] SWEEP_LAST = {1'b0, {A{1'b1}}};

    state_t       stateReg, stateNext;
    logic [A:0]   cntReg;

    logic         s1Valid;
    logic [A-1:0] s1Addr;
    logic [D-1:0] s1Set, s1Clr;

    logic         prevWrValid;
    logic [A-1:0] prevWrAddr;
    logic [D-1:0] prevWrData;

    logic         accept, fwd;
    logic [D-1:0] oldData, newData;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateReg <= ST_RST;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == ST_INIT)
                cntReg <= cntReg + 1'b1;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_RST:  stateNext = ST_INIT;
            ST_INIT: if (cntReg == SWEEP_LAST) stateNext = ST_RUN;
            default: stateNext = stateReg;
        endcase
    end

    assign accept = (stateReg == ST_RUN) && Bus.ReqValid;

    // The RAM returns pre-write data when read and written in the same cycle,
    // so the previous cycle's write must be bypassed for the same address.
    assign fwd     = prevWrValid && (prevWrAddr == s1Addr);
    assign oldData = fwd ? prevWrData : Bus.RamRdData;
    assign newData = `RMW_NEW_VAL(oldData, s1Set, s1Clr);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1Valid     <= 1'b0;
            s1Addr      <= '0;
            s1Set       <= '0;
            s1Clr       <= '0;
            prevWrValid <= 1'b0;
            prevWrAddr  <= '0;
            prevWrData  <= '0;
        end else begin
            s1Valid     <= accept;
            if (accept) begin
                s1Addr <= Bus.ReqAddr;
                s1Set  <= Bus.ReqSetMask;
                s1Clr  <= Bus.ReqClrMask;
            end
            prevWrValid <= s1Valid;
            prevWrAddr  <= s1Addr;
            prevWrData  <= newData;
        end
    end

    assign Bus.ReqReady  = (stateReg == ST_RUN);
    assign Bus.InitDone  = (stateReg == ST_RUN);
    assign Bus.RamRdEnb  = accept;
    assign Bus.RamRdAddr = accept ? Bus.ReqAddr : '0;

    always_comb begin
        Bus.RamWrEnb  = 1'b0;
        Bus.RamWrAddr = '0;
        Bus.RamWrData = '0;
        if (stateReg == ST_INIT) begin
            Bus.RamWrEnb  = 1'b1;
            Bus.RamWrAddr = cntReg[A-1:0];
        end else if (s1Valid) begin
            Bus.RamWrEnb  = 1'b1;
            Bus.RamWrAddr = s1Addr;
            Bus.RamWrData = newData;
        end
    end

`ifdef RAM_RMW_RSP_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Bus.RspValid   <= 1'b0;
            Bus.RspAddr    <= '0;
            Bus.RspOldData <= '0;
            Bus.RspNewData <= '0;
        end else begin
            Bus.RspValid   <= s1Valid;
            Bus.RspAddr    <= s1Addr;
            Bus.RspOldData <= oldData;
            Bus.RspNewData <= newData;
        end
    end
`endif

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Directed bench for ram_rmw_ctrl (A=4, D=8) with a registered-read RAM and an
// update-level reference model; response checks enabled under RAM_RMW_RSP_EN.
module tb_ram_rmw_ctrl;

    localparam int A = 4;
    localparam int D = 8;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;

    always #5 Clk = ~Clk;

    ram_rmw_ctrl_if #(.A(A), .D(D)) bus ();

    ram_rmw_ctrl #(.A(A), .D(D)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Bus   (bus)
    );

    // Environment RAM: registered read, read-during-write returns old data.
    logic [D-1:0] ram [2**A];
    initial for (int i = 0; i < 2**A; i++) ram[i] = 8'hAA;
    initial bus.RamRdData = '0;
    always @(posedge Clk) begin
        if (bus.RamRdEnb) bus.RamRdData <= ram[bus.RamRdAddr];
        if (bus.RamWrEnb) ram[bus.RamWrAddr] <= bus.RamWrData;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Clock edges seen since reset release: 0 = reset cycle, 1..16 = sweep, then run.
    int edges = 0;
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) edges <= 0;
        else if (edges < 1000) edges <= edges + 1;
    end

    // Reference model: memory contents as a sequence of applied updates.
    logic [D-1:0] refMem [2**A];
    logic         pendV = 1'b0, rspV = 1'b0;
    logic [A-1:0] pendA = '0, rspA = '0;
    logic [D-1:0] pendOld = '0, pendNew = '0, rspOld = '0, rspNew = '0;
    int           initWrites = 0;
    logic [D-1:0] rspOldQ[$], rspNewQ[$];

    always @(negedge Clk) begin
        if (!Rst_n || edges == 0) begin
            check("rst_wr_enb", bus.RamWrEnb, 0);
            check("rst_rd_enb", bus.RamRdEnb, 0);
            check("rst_ready", bus.ReqReady, 0);
            check("rst_init_done", bus.InitDone, 0);
`ifdef RAM_RMW_RSP_EN
            check("rst_rsp_valid", bus.RspValid, 0);
`endif
            pendV = 1'b0;
            rspV  = 1'b0;
        end else if (edges <= 2**A) begin
            check("sweep_wr_enb", bus.RamWrEnb, 1);
            check("sweep_wr_addr", bus.RamWrAddr, edges - 1);
            check("sweep_wr_data", bus.RamWrData, 0);
            check("sweep_ready", bus.ReqReady, 0);
            check("sweep_rd_enb", bus.RamRdEnb, 0);
            refMem[edges-1] = '0;
            initWrites++;
            pendV = 1'b0;
            rspV  = 1'b0;
        end else begin
            check("run_ready", bus.ReqReady, 1);
            check("run_init_done", bus.InitDone, 1);
            check("run_rd_enb", bus.RamRdEnb, bus.ReqValid);
            if (bus.ReqValid) check("run_rd_addr", bus.RamRdAddr, bus.ReqAddr);
            check("run_wr_enb", bus.RamWrEnb, pendV);
            if (pendV) begin
                check("run_wr_addr", bus.RamWrAddr, pendA);
                check("run_wr_data", bus.RamWrData, pendNew);
            end
`ifdef RAM_RMW_RSP_EN
            check("rsp_valid", bus.RspValid, rspV);
            if (rspV) begin
                check("rsp_addr", bus.RspAddr, rspA);
                check("rsp_old", bus.RspOldData, rspOld);
                check("rsp_new", bus.RspNewData, rspNew);
            end
            if (bus.RspValid && bus.RspAddr == 4'd7) begin
                rspOldQ.push_back(bus.RspOldData);
                rspNewQ.push_back(bus.RspNewData);
            end
`endif
            rspV = pendV; rspA = pendA; rspOld = pendOld; rspNew = pendNew;
            pendV = bus.ReqValid;
            if (bus.ReqValid) begin
                pendA   = bus.ReqAddr;
                pendOld = refMem[bus.ReqAddr];
                pendNew = (pendOld & ~bus.ReqClrMask) | bus.ReqSetMask;
                refMem[bus.ReqAddr] = pendNew;
                $display("txn addr=%0d set=%02h clr=%02h old=%02h new=%02h",
                         bus.ReqAddr, bus.ReqSetMask, bus.ReqClrMask, pendOld, pendNew);
            end
        end
    end

    task automatic idle(input int n);
        bus.ReqValid = 1'b0;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Drives a request for exactly one cycle; caller chains calls for back-to-back traffic.
    task automatic req(input logic [A-1:0] a, input logic [D-1:0] s, input logic [D-1:0] c);
        bus.ReqValid   = 1'b1;
        bus.ReqAddr    = a;
        bus.ReqSetMask = s;
        bus.ReqClrMask = c;
        @(posedge Clk);
        #1;
        bus.ReqValid = 1'b0;
    endtask

    task automatic waitInit();
        int n;
        n = 0;
        while (!bus.InitDone && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("init_latency", n, 17);
    endtask

    initial begin
        bus.ReqValid   = 1'b0;
        bus.ReqAddr    = '0;
        bus.ReqSetMask = '0;
        bus.ReqClrMask = '0;
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;

        // T1: zero sweep
        waitInit();
        check("t1_sweep_writes", initWrites, 16);
        check("t1_ram0", ram[0], 8'h00);
        check("t1_ram15", ram[15], 8'h00);

        // T2: set then clear on one address
        req(4'd3, 8'h0F, 8'h00);
        idle(3);
        req(4'd3, 8'h00, 8'h05);
        idle(3);
        check("t2_ram3", ram[3], 8'h0A);
        check("t2_model3", refMem[3], 8'h0A);

        // T3: back-to-back same address, forwarding twice
        req(4'd7, 8'h01, 8'h00);
        req(4'd7, 8'h02, 8'h00);
        req(4'd7, 8'h04, 8'h00);
        idle(3);
        check("t3_ram7", ram[7], 8'h07);
        check("t3_model7", refMem[7], 8'h07);

        // T4: alternating addresses, no forwarding
        req(4'd1, 8'h80, 8'h00);
        req(4'd2, 8'h40, 8'h00);
        req(4'd1, 8'h40, 8'h00);
        req(4'd2, 8'h80, 8'h00);
        idle(3);
        check("t4_ram1", ram[1], 8'hC0);
        check("t4_ram2", ram[2], 8'hC0);

        // T5: set wins over clear
        req(4'd5, 8'hFF, 8'hFF);
        idle(3);
        check("t5_ram5", ram[5], 8'hFF);

`ifdef RAM_RMW_RSP_EN
        // T7: responses of the T3 burst
        check("t7_rsp_count", rspOldQ.size(), 3);
        if (rspOldQ.size() == 3) begin
            check("t7_old0", rspOldQ[0], 8'h00);
            check("t7_new0", rspNewQ[0], 8'h01);
            check("t7_old1", rspOldQ[1], 8'h01);
            check("t7_new1", rspNewQ[1], 8'h03);
            check("t7_old2", rspOldQ[2], 8'h03);
            check("t7_new2", rspNewQ[2], 8'h07);
        end
`endif

        // T6: reset during S1 of an update drops its write
        req(4'd9, 8'h33, 8'h00);
        #1 Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        check("t6_ram9_dropped", ram[9], 8'h00);
        Rst_n = 1'b1;
        waitInit();
        check("t6_ram9", ram[9], 8'h00);
        check("t6_ram5_swept", ram[5], 8'h00);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
